// File: rtl/busy_table_param_pkg.sv
// Shared defaults and helpers for the parametrised rename-stage busy table.
package busy_table_param_pkg;

    localparam int NUM_PREG_D = 128;
    localparam int PRW_D      = 7;
    localparam int RN_W_D     = 4;
    localparam int WK_W_D     = 7;
    localparam int CNT_W_D    = 8;

    // Mask with the lowest n bits set; selects the slots older than slot n.
    function automatic logic [31:0] lower_mask(input int n);
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/busy_table_param_if.sv
// Rename-group bus between the rename stage (master) and the busy table (slave).
interface busy_table_param_if
    import busy_table_param_pkg::*;
#(
    parameter int PRW   = PRW_D,
    parameter int RN_W  = RN_W_D,
    parameter int WK_W  = WK_W_D,
    parameter int CNT_W = CNT_W_D
);
    logic                     busy_stop;
    logic                     busy_flash;
    logic [WK_W-1:0]          unbusy_able;
    logic [WK_W*PRW-1:0]      unbusy_addr;
    logic [RN_W*2-1:0]        src_able;
    logic [RN_W*2*PRW-1:0]    src_addr;
    logic [RN_W-1:0]          rd_able;
    logic [RN_W*PRW-1:0]      rd_addr;

    logic [RN_W*2-1:0]        src_busy_out;
    logic [RN_W*2-1:0]        src_able_out;
    logic [RN_W*2*PRW-1:0]    src_addr_out;
    logic [RN_W-1:0]          rd_able_out;
    logic [RN_W*PRW-1:0]      rd_addr_out;
    logic [CNT_W-1:0]         busy_cnt;

    modport master (
        output busy_stop, busy_flash, unbusy_able, unbusy_addr,
               src_able, src_addr, rd_able, rd_addr,
        input  src_busy_out, src_able_out, src_addr_out,
               rd_able_out, rd_addr_out, busy_cnt
    );

    modport slave (
        input  busy_stop, busy_flash, unbusy_able, unbusy_addr,
               src_able, src_addr, rd_able, rd_addr,
        output src_busy_out, src_able_out, src_addr_out,
               rd_able_out, rd_addr_out, busy_cnt
    );

endinterface

// File: rtl/busy_table_param_lookup_port.sv
// One source-operand readiness lookup with wakeup and older-slot bypass.
module busy_lookup_port #(
    parameter int PRW  = 7,
    parameter int RN_W = 4,
    parameter int WK_W = 7
) (
    input  logic                 src_able,
    input  logic [PRW-1:0]       src_addr,
    input  logic                 busy_bit,
    input  logic                 flash,
    input  logic [WK_W-1:0]      unbusy_able,
    input  logic [WK_W*PRW-1:0]  unbusy_addr,
    input  logic [RN_W-1:0]      older_able,
    input  logic [RN_W*PRW-1:0]  rd_addr,
    output logic                 src_busy
);

    logic wake_hit;
    logic older_hit;

    always_comb begin
        wake_hit  = 1'b0;
        older_hit = 1'b0;
        for (int k = 0; k < WK_W; k++) begin
            if (unbusy_able[k] && (unbusy_addr[k*PRW +: PRW] == src_addr))
                wake_hit = 1'b1;
        end
        // older_able already excludes this slot and every younger one
        for (int t = 0; t < RN_W; t++) begin
            if (older_able[t] && (rd_addr[t*PRW +: PRW] == src_addr))
                older_hit = 1'b1;
        end
        src_busy = !flash && src_able && (src_addr != '0)
                   && ((busy_bit && !wake_hit) || older_hit);
    end

endmodule

// File: rtl/busy_table_param.sv
// Physical-register busy table with lookup bypass and busy counter.
// Define BUSY_OUTREG_EN to register every output except busy_cnt.
module busy_table_param
    import busy_table_param_pkg::*;
#(
    parameter int NUM_PREG = NUM_PREG_D,
    parameter int PRW      = PRW_D,
    parameter int RN_W     = RN_W_D,
    parameter int WK_W     = WK_W_D,
    parameter int CNT_W    = CNT_W_D
) (
    input  logic               clk,
    input  logic               rst,
    busy_table_param_if.slave  bus
);

    logic [NUM_PREG-1:0] busy_reg;
    logic [NUM_PREG-1:0] busy_next;
    logic [NUM_PREG-1:0] set_vec;
    logic [NUM_PREG-1:0] clr_vec;
    logic [CNT_W-1:0]    busy_cnt_reg;
    logic [CNT_W-1:0]    cnt_next;
    logic [RN_W*2-1:0]   src_busy_comb;

    // Allocation is applied after wakeup so it wins on a same-preg collision.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int s = 0; s < RN_W; s++) begin
            if (!bus.busy_stop && bus.rd_able[s])
                set_vec[bus.rd_addr[s*PRW +: PRW]] = 1'b1;
        end
        for (int k = 0; k < WK_W; k++) begin
            if (bus.unbusy_able[k])
                clr_vec[bus.unbusy_addr[k*PRW +: PRW]] = 1'b1;
        end
        busy_next    = bus.busy_flash ? '0 : ((busy_reg & ~clr_vec) | set_vec);
        busy_next[0] = 1'b0;
        cnt_next = '0;
        for (int p = 0; p < NUM_PREG; p++)
            cnt_next = cnt_next + CNT_W'(busy_next[p]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg     <= '0;
            busy_cnt_reg <= '0;
        end else begin
            busy_reg     <= busy_next;
            busy_cnt_reg <= cnt_next;
        end
    end

    assign bus.busy_cnt = busy_cnt_reg;

    generate
        for (genvar gi = 0; gi < RN_W*2; gi++) begin : g_lookup
            busy_lookup_port #(
                .PRW  (PRW),
                .RN_W (RN_W),
                .WK_W (WK_W)
            ) u_port (
                .src_able    (bus.src_able[gi]),
                .src_addr    (bus.src_addr[gi*PRW +: PRW]),
                .busy_bit    (busy_reg[bus.src_addr[gi*PRW +: PRW]]),
                .flash       (bus.busy_flash),
                .unbusy_able (bus.unbusy_able),
                .unbusy_addr (bus.unbusy_addr),
                .older_able  (bus.rd_able & RN_W'(lower_mask(gi/2))),
                .rd_addr     (bus.rd_addr),
                .src_busy    (src_busy_comb[gi])
            );
        end
    endgenerate

`ifdef BUSY_OUTREG_EN
    logic [RN_W*2-1:0]     src_busy_reg;
    logic [RN_W*2-1:0]     src_able_reg;
    logic [RN_W*2*PRW-1:0] src_addr_reg;
    logic [RN_W-1:0]       rd_able_reg;
    logic [RN_W*PRW-1:0]   rd_addr_reg;

    // Flush beats stall so no stale valid survives a stalled flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_busy_reg <= '0;
            src_able_reg <= '0;
            src_addr_reg <= '0;
            rd_able_reg  <= '0;
            rd_addr_reg  <= '0;
        end else if (bus.busy_flash) begin
            src_busy_reg <= '0;
            src_able_reg <= '0;
            rd_able_reg  <= '0;
        end else if (!bus.busy_stop) begin
            src_busy_reg <= src_busy_comb;
            src_able_reg <= bus.src_able;
            src_addr_reg <= bus.src_addr;
            rd_able_reg  <= bus.rd_able;
            rd_addr_reg  <= bus.rd_addr;
        end
    end

    assign bus.src_busy_out = src_busy_reg;
    assign bus.src_able_out = src_able_reg;
    assign bus.src_addr_out = src_addr_reg;
    assign bus.rd_able_out  = rd_able_reg;
    assign bus.rd_addr_out  = rd_addr_reg;
`else
    assign bus.src_busy_out = src_busy_comb;
    assign bus.src_able_out = bus.src_able;
    assign bus.src_addr_out = bus.src_addr;
    assign bus.rd_able_out  = bus.rd_able;
    assign bus.rd_addr_out  = bus.rd_addr;
`endif

endmodule

// File: tb/tb_busy_table_param.sv
// Randomized and directed bench for busy_table_param against a behavioural table model.
module tb_busy_table_param;
    import busy_table_param_pkg::*;

    localparam int NP    = NUM_PREG_D;
    localparam int PRW   = PRW_D;
    localparam int RN_W  = RN_W_D;
    localparam int WK_W  = WK_W_D;
    localparam int CNT_W = CNT_W_D;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    busy_table_param_if #(.PRW(PRW), .RN_W(RN_W), .WK_W(WK_W), .CNT_W(CNT_W)) bus ();

    busy_table_param #(
        .NUM_PREG (NP),
        .PRW      (PRW),
        .RN_W     (RN_W),
        .WK_W     (WK_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;

    bit mdl_busy [NP];
    logic [RN_W*2-1:0]     o_busy  = '0;
    logic [RN_W*2-1:0]     o_sable = '0;
    logic [RN_W*2*PRW-1:0] o_saddr = '0;
    logic [RN_W-1:0]       o_rable = '0;
    logic [RN_W*PRW-1:0]   o_raddr = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.busy_stop   = 1'b0;
        bus.busy_flash  = 1'b0;
        bus.unbusy_able = '0;
        bus.unbusy_addr = '0;
        bus.src_able    = '0;
        bus.src_addr    = '0;
        bus.rd_able     = '0;
        bus.rd_addr     = '0;
    endtask

    task automatic set_src(input int i, input int a);
        bus.src_able[i]             = 1'b1;
        bus.src_addr[i*PRW +: PRW]  = PRW'(a);
    endtask

    task automatic alloc(input int s, input int a);
        bus.rd_able[s]              = 1'b1;
        bus.rd_addr[s*PRW +: PRW]   = PRW'(a);
    endtask

    task automatic wake(input int k, input int a);
        bus.unbusy_able[k]            = 1'b1;
        bus.unbusy_addr[k*PRW +: PRW] = PRW'(a);
    endtask

    function automatic bit is_woken(input int a);
        for (int k = 0; k < WK_W; k++)
            if (bus.unbusy_able[k] && int'(bus.unbusy_addr[k*PRW +: PRW]) == a) return 1'b1;
        return 1'b0;
    endfunction

    // Readiness straight from the rules: busy-and-not-woken, or produced by an older slot.
    function automatic logic [RN_W*2-1:0] model_lookup();
        logic [RN_W*2-1:0] r;
        r = '0;
        for (int i = 0; i < RN_W*2; i++) begin
            int a;
            bit older;
            a = int'(bus.src_addr[i*PRW +: PRW]);
            older = 1'b0;
            for (int t = 0; t < i/2; t++)
                if (bus.rd_able[t] && int'(bus.rd_addr[t*PRW +: PRW]) == a) older = 1'b1;
            r[i] = !bus.busy_flash && bus.src_able[i] && a != 0
                   && ((mdl_busy[a] && !is_woken(a)) || older);
        end
        return r;
    endfunction

    task automatic cycle();
        logic [RN_W*2-1:0] eb;
        bit nb [NP];
        int cnt;
        eb = model_lookup();
`ifndef BUSY_OUTREG_EN
        @(negedge clk);
        check("src_busy", 64'(bus.src_busy_out), 64'(eb));
        check("src_able", 64'(bus.src_able_out), 64'(bus.src_able));
        check("src_addr", 64'(bus.src_addr_out), 64'(bus.src_addr));
        check("rd_able",  64'(bus.rd_able_out),  64'(bus.rd_able));
        check("rd_addr",  64'(bus.rd_addr_out),  64'(bus.rd_addr));
`endif
        nb = mdl_busy;
        for (int k = 0; k < WK_W; k++)
            if (bus.unbusy_able[k]) nb[int'(bus.unbusy_addr[k*PRW +: PRW])] = 1'b0;
        for (int s = 0; s < RN_W; s++)
            if (!bus.busy_stop && bus.rd_able[s]) nb[int'(bus.rd_addr[s*PRW +: PRW])] = 1'b1;
        if (bus.busy_flash)
            for (int p = 0; p < NP; p++) nb[p] = 1'b0;
        nb[0] = 1'b0;
        cnt = 0;
        for (int p = 0; p < NP; p++) cnt += int'(nb[p]);
        if (bus.busy_flash) begin
            o_busy = '0; o_sable = '0; o_rable = '0;
        end else if (!bus.busy_stop) begin
            o_busy = eb; o_sable = bus.src_able; o_saddr = bus.src_addr;
            o_rable = bus.rd_able; o_raddr = bus.rd_addr;
        end
        @(posedge clk);
        #1;
        mdl_busy = nb;
        check("busy_cnt", 64'(bus.busy_cnt), 64'(cnt));
`ifdef BUSY_OUTREG_EN
        check("src_busy", 64'(bus.src_busy_out), 64'(o_busy));
        check("src_able", 64'(bus.src_able_out), 64'(o_sable));
        check("src_addr", 64'(bus.src_addr_out), 64'(o_saddr));
        check("rd_able",  64'(bus.rd_able_out),  64'(o_rable));
        check("rd_addr",  64'(bus.rd_addr_out),  64'(o_raddr));
`endif
        $display("cyc %0d flash=%0b stop=%0b busy_cnt=%0d exp_cnt=%0d", cyc, bus.busy_flash,
                 bus.busy_stop, bus.busy_cnt, cnt);
        cyc++;
    endtask

    function automatic int rnd_addr();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, NP-1));
        return int'($urandom_range(0, 15));
    endfunction

    initial begin
        for (int p = 0; p < NP; p++) mdl_busy[p] = 1'b0;
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_cnt",      64'(bus.busy_cnt),     64'd0);
        check("rst_src_busy", 64'(bus.src_busy_out), 64'd0);
        check("rst_src_able", 64'(bus.src_able_out), 64'd0);
        check("rst_rd_able",  64'(bus.rd_able_out),  64'd0);
        rst = 1'b0;

        // allocate then look up the same preg
        clear_inputs(); alloc(0, 5); cycle();
        check("t1_cnt", 64'(bus.busy_cnt), 64'd1);
        clear_inputs(); set_src(0, 5); cycle();
        // wakeup bypass on a busy preg
        clear_inputs(); set_src(0, 5); wake(3, 5); cycle();
        check("t2_cnt", 64'(bus.busy_cnt), 64'd0);
        // intra-group bypass from an older slot
        clear_inputs(); alloc(0, 9); set_src(4, 9); set_src(0, 9); cycle();
        clear_inputs(); bus.busy_flash = 1'b1; cycle();
        // allocation beats wakeup; stall blocks allocation but not wakeup
        clear_inputs(); alloc(0, 20); cycle();
        clear_inputs(); alloc(1, 12); wake(0, 12); set_src(2, 12); cycle();
        check("t4_alloc_wins", 64'(bus.busy_cnt), 64'd2);
        clear_inputs(); bus.busy_stop = 1'b1; alloc(2, 12); wake(0, 12); wake(1, 20); cycle();
        check("t4_stop", 64'(bus.busy_cnt), 64'd0);
        // ten busy entries then flush with a simultaneous allocation
        clear_inputs(); for (int s = 0; s < 4; s++) alloc(s, 100 + s); cycle();
        clear_inputs(); for (int s = 0; s < 4; s++) alloc(s, 104 + s); cycle();
        clear_inputs(); alloc(0, 108); alloc(1, 109); cycle();
        check("t5_ten", 64'(bus.busy_cnt), 64'd10);
        clear_inputs(); bus.busy_flash = 1'b1; alloc(0, 30);
        for (int i = 0; i < RN_W*2; i++) set_src(i, 100 + i);
        cycle();
        check("t5_flush", 64'(bus.busy_cnt), 64'd0);
        // preg 0 never busy
        clear_inputs(); alloc(0, 0); set_src(2, 0); set_src(1, 0); cycle();
        clear_inputs(); set_src(0, 0); cycle();
        check("t6_cnt", 64'(bus.busy_cnt), 64'd0);

        for (int n = 0; n < 400; n++) begin
            clear_inputs();
            bus.busy_flash = ($urandom_range(0, 24) == 0);
            bus.busy_stop  = ($urandom_range(0, 4) == 0);
            for (int k = 0; k < WK_W; k++) if ($urandom_range(0, 2) == 0) wake(k, rnd_addr());
            for (int s = 0; s < RN_W; s++) if ($urandom_range(0, 1) == 0) alloc(s, rnd_addr());
            for (int i = 0; i < RN_W*2; i++) if ($urandom_range(0, 3) != 0) set_src(i, rnd_addr());
            cycle();
        end
        clear_inputs(); cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
